// File: rtl/key_input_conditioner.sv
// rtl/key_input_conditioner.sv - N-channel key synchroniser, debouncer, press/release and hold-to-repeat pulses
// Define KEY_PRIORITY_EN to pass only the lowest-index o_pos/o_repeat bit in a cycle.
module key_input_conditioner #(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 16,
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_in,
  input  logic            i_repeat_en,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_pos,
  output logic [N_CH-1:0] o_neg,
  output logic [N_CH-1:0] o_repeat
);

  localparam int RPT_W = CNT_W + 10;
  localparam logic [N_CH-1:0]  POL    = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [RPT_W-1:0] RD_MAX = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_MAX = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, RPT} rpt_state_t;

  logic [N_CH-1:0] sync1, sync2;
  logic [N_CH-1:0] sync_lvl;
  logic [N_CH-1:0] toggle;
  logic [N_CH-1:0] pos_raw, neg_raw, rpt_raw;
  logic [N_CH-1:0] pos_f, rpt_f;

  // Sync flops hold raw pin values; the reset value is the physical "released" level.
  assign sync_lvl = sync2 ^ POL;
  assign pos_raw  = toggle & ~o_level;
  assign neg_raw  = toggle & o_level;

`ifdef KEY_PRIORITY_EN
  assign pos_f = pos_raw & (~pos_raw + N_CH'(1));
  assign rpt_f = rpt_raw & (~rpt_raw + N_CH'(1));
`else
  assign pos_f = pos_raw;
  assign rpt_f = rpt_raw;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1    <= POL;
      sync2    <= POL;
      o_level  <= '0;
      o_pos    <= '0;
      o_neg    <= '0;
      o_repeat <= '0;
    end else begin
      sync1    <= i_in;
      sync2    <= sync1;
      o_level  <= o_level ^ toggle;
      o_pos    <= pos_f;
      o_neg    <= neg_raw;
      o_repeat <= rpt_f;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] db_cnt;
    logic [RPT_W-1:0] rc_q, rc_d;
    rpt_state_t       st_q, st_d;
    logic             rpt_c;

    assign toggle[g]  = (sync_lvl[g] != o_level[g]) && (db_cnt == DB_MAX);
    assign rpt_raw[g] = rpt_c;

    // Counter never passes DB_MAX: it clears on agreement or on acceptance.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        db_cnt <= '0;
      end else if ((sync_lvl[g] == o_level[g]) || toggle[g]) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        st_q <= IDLE;
        rc_q <= '0;
      end else begin
        st_q <= st_d;
        rc_q <= rc_d;
      end
    end

    // The FSM is armed by the unfiltered press, so priority filtering never starves repeat timing.
    always_comb begin
      st_d  = st_q;
      rc_d  = rc_q;
      rpt_c = 1'b0;
      case (st_q)
        IDLE: begin
          if (pos_raw[g] && i_repeat_en) begin
            st_d = DELAY;
            rc_d = '0;
          end
        end
        DELAY: begin
          if (!o_level[g] || !i_repeat_en) begin
            st_d = IDLE;
            rc_d = '0;
          end else if (rc_q == RD_MAX) begin
            rpt_c = 1'b1;
            st_d  = RPT;
            rc_d  = '0;
          end else begin
            rc_d = rc_q + RPT_W'(1);
          end
        end
        RPT: begin
          if (!o_level[g] || !i_repeat_en) begin
            st_d = IDLE;
            rc_d = '0;
          end else if (rc_q == RP_MAX) begin
            rpt_c = 1'b1;
            rc_d  = '0;
          end else begin
            rc_d = rc_q + RPT_W'(1);
          end
        end
        default: begin
          st_d = IDLE;
          rc_d = '0;
        end
      endcase
    end
  end

endmodule
